set_associative_tag_unit: RTL and testbench

SET_ASSOCIATIVE_TAG_UNIT -- requirements
Module: set_associative_tag_unit

---
 rtl/set_associative_tag_unit_if.sv | 40 ++++
 rtl/set_associative_tag_unit.sv | 138 +++++++++++++
 tb/tb_set_associative_tag_unit.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/set_associative_tag_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : set_associative_tag_unit_if
//  Purpose  : Lookup / write / flush bus of the set-associative tag unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface set_associative_tag_unit_if #(
    parameter int TAG_WIDTH   = 8,
    parameter int INDEX_WIDTH = 4,
    parameter int WAY_COUNT   = 4,
    parameter int STATE_WIDTH = 2
);
    localparam int c_way_width = $clog2(WAY_COUNT);

    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   tagIn;
    logic [c_way_width-1:0] wayIn;
    logic                   writeTag;
    logic                   writeState;
    logic [STATE_WIDTH-1:0] stateIn;
    logic                   touch;
    logic                   flushStart;
    logic                   hit;
    logic [c_way_width-1:0] hitWay;
    logic [c_way_width-1:0] victimWay;
    logic [TAG_WIDTH-1:0]   tagOut;
    logic [STATE_WIDTH-1:0] stateOut;
    logic                   flushBusy;

    modport master (
        output index, tagIn, wayIn, writeTag, writeState, stateIn, touch, flushStart,
        input  hit, hitWay, victimWay, tagOut, stateOut, flushBusy
    );

    modport slave (
        input  index, tagIn, wayIn, writeTag, writeState, stateIn, touch, flushStart,
        output hit, hitWay, victimWay, tagOut, stateOut, flushBusy
    );
endinterface
`default_nettype wire

// File: rtl/set_associative_tag_unit.sv
`default_nettype none
// ============================================================================
//  Module   : set_associative_tag_unit
//  Purpose  : Tag/state store with true-LRU ages, zero-latency lookup and a
//             one-set-per-cycle invalidate sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module set_associative_tag_unit #(
    parameter int                     TAG_WIDTH     = 8,
    parameter int                     INDEX_WIDTH   = 4,
    parameter int                     WAY_COUNT     = 4,
    parameter int                     STATE_WIDTH   = 2,
    parameter logic [STATE_WIDTH-1:0] INVALID_STATE = '0
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    set_associative_tag_unit_if.slave bus
);
    localparam int c_way_width = $clog2(WAY_COUNT);
    localparam int c_num_sets  = 1 << INDEX_WIDTH;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } fsm_t;

    fsm_t                   r_fsm;
    logic [INDEX_WIDTH-1:0] r_sweep_cnt;
    logic                   r_busy;

    logic [c_num_sets-1:0][WAY_COUNT-1:0][TAG_WIDTH-1:0]   r_tag;
    logic [c_num_sets-1:0][WAY_COUNT-1:0][STATE_WIDTH-1:0] r_state;
    logic [c_num_sets-1:0][WAY_COUNT-1:0][c_way_width-1:0] r_age;

    logic                   w_match_any;
    logic [c_way_width-1:0] w_match_way;
    logic                   w_inv_any;
    logic [c_way_width-1:0] w_inv_way;
    logic [c_way_width-1:0] w_lru_way;
    logic [c_way_width-1:0] w_touch_age;
    logic                   w_hit;

    // Descending scan so the lowest-numbered qualifying way wins.
    always_comb begin
        w_match_any = 1'b0;
        w_match_way = '0;
        w_inv_any   = 1'b0;
        w_inv_way   = '0;
        w_lru_way   = '0;
        for (int w = WAY_COUNT - 1; w >= 0; w--) begin
            if (r_state[bus.index][w] != INVALID_STATE &&
                r_tag[bus.index][w] == bus.tagIn) begin
                w_match_any = 1'b1;
                w_match_way = c_way_width'(w);
            end
            if (r_state[bus.index][w] == INVALID_STATE) begin
                w_inv_any = 1'b1;
                w_inv_way = c_way_width'(w);
            end
            if (r_age[bus.index][w] == c_way_width'(WAY_COUNT - 1)) begin
                w_lru_way = c_way_width'(w);
            end
        end
    end

    assign w_hit       = w_match_any & ~r_busy;
    assign w_touch_age = r_age[bus.index][bus.wayIn];

    assign bus.hit       = w_hit;
    assign bus.hitWay    = w_hit ? w_match_way : '0;
    assign bus.victimWay = w_inv_any ? w_inv_way : w_lru_way;
    assign bus.tagOut    = r_tag[bus.index][bus.wayIn];
    assign bus.stateOut  = r_state[bus.index][bus.wayIn];
    assign bus.flushBusy = r_busy;

    // Tags are deliberately left out of reset and survive a flush.
    always_ff @(posedge clock) begin
        if (r_fsm == IDLE && bus.writeTag) begin
            r_tag[bus.index][bus.wayIn] <= bus.tagIn;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fsm       <= IDLE;
            r_sweep_cnt <= '0;
            r_busy      <= 1'b0;
            for (int s = 0; s < c_num_sets; s++) begin
                for (int w = 0; w < WAY_COUNT; w++) begin
                    r_state[s][w] <= INVALID_STATE;
                    r_age[s][w]   <= c_way_width'(w);
                end
            end
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (bus.writeState) begin
                        r_state[bus.index][bus.wayIn] <= bus.stateIn;
                    end
                    // Ways younger than the touched one age by one; the
                    // ages of the set remain a permutation.
                    if (bus.touch) begin
                        for (int w = 0; w < WAY_COUNT; w++) begin
                            if (c_way_width'(w) == bus.wayIn) begin
                                r_age[bus.index][w] <= '0;
                            end else if (r_age[bus.index][w] < w_touch_age) begin
                                r_age[bus.index][w] <= r_age[bus.index][w] + 1'b1;
                            end
                        end
                    end
                    if (bus.flushStart) begin
                        r_fsm       <= SWEEP;
                        r_busy      <= 1'b1;
                        r_sweep_cnt <= '0;
                    end
                end
                SWEEP: begin
                    for (int w = 0; w < WAY_COUNT; w++) begin
                        r_state[r_sweep_cnt][w] <= INVALID_STATE;
                        r_age[r_sweep_cnt][w]   <= c_way_width'(w);
                    end
                    if (r_sweep_cnt == INDEX_WIDTH'(c_num_sets - 1)) begin
                        r_fsm       <= IDLE;
                        r_busy      <= 1'b0;
                        r_sweep_cnt <= '0;
                    end else begin
                        r_sweep_cnt <= r_sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    r_fsm  <= IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_set_associative_tag_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_set_associative_tag_unit
//  Purpose  : Scoreboard bench for set_associative_tag_unit (4 ways, 4 sets).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_set_associative_tag_unit;
    localparam int TW = 4;
    localparam int IW = 2;
    localparam int WC = 4;
    localparam int SW = 2;
    localparam int NS = 4;

    localparam int SEL_HIT = 0, SEL_HITWAY = 1, SEL_VICTIM = 2;
    localparam int SEL_TAG = 3, SEL_STATE = 4, SEL_BUSY = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    set_associative_tag_unit_if #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .WAY_COUNT(WC),
                                  .STATE_WIDTH(SW)) bus ();

    set_associative_tag_unit #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .WAY_COUNT(WC),
                               .STATE_WIDTH(SW), .INVALID_STATE(2'd0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    string       q_name[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];

    logic [TW-1:0] m_tag[NS][WC];
    logic [SW-1:0] m_state[NS][WC];
    int            m_age[NS][WC];
    bit            m_busy;
    int            m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_HIT:    return 32'(bus.hit);
            SEL_HITWAY: return 32'(bus.hitWay);
            SEL_VICTIM: return 32'(bus.victimWay);
            SEL_TAG:    return 32'(bus.tagOut);
            SEL_STATE:  return 32'(bus.stateOut);
            default:    return 32'(bus.flushBusy);
        endcase
    endfunction

    task automatic push(input string nm, input int sel, input int val);
        q_name.push_back(nm);
        q_sel.push_back(sel);
        q_exp.push_back(32'(val));
    endtask

    task automatic drain();
        while (q_sel.size() > 0) begin
            string nm;
            int sel;
            logic [31:0] ex;
            nm = q_name.pop_front();
            sel = q_sel.pop_front();
            ex = q_exp.pop_front();
            check(nm, observe(sel), ex);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < WC; w++) begin
                m_state[s][w] = '0;
                m_age[s][w]   = w;
            end
        m_busy = 1'b0;
        m_cnt  = 0;
    endtask

    // Next-state of the reference model from the inputs about to be sampled.
    task automatic model_edge();
        int i, wy, a;
        i  = int'(bus.index);
        wy = int'(bus.wayIn);
        if (m_busy) begin
            for (int w = 0; w < WC; w++) begin
                m_state[m_cnt][w] = '0;
                m_age[m_cnt][w]   = w;
            end
            if (m_cnt == NS - 1) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            if (bus.writeTag)   m_tag[i][wy]   = bus.tagIn;
            if (bus.writeState) m_state[i][wy] = bus.stateIn;
            if (bus.touch) begin
                a = m_age[i][wy];
                for (int w = 0; w < WC; w++)
                    if (w != wy && m_age[i][w] < a) m_age[i][w]++;
                m_age[i][wy] = 0;
            end
            if (bus.flushStart) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic predict(input string tg);
        int i, wy, hw, vic, lru;
        bit h;
        i = int'(bus.index);
        wy = int'(bus.wayIn);
        h = 1'b0; hw = 0; vic = -1; lru = 0;
        for (int w = WC - 1; w >= 0; w--) begin
            if (m_state[i][w] != 0 && m_tag[i][w] == bus.tagIn) begin
                h = 1'b1;
                hw = w;
            end
            if (m_state[i][w] == 0) vic = w;
            if (m_age[i][w] == WC - 1) lru = w;
        end
        if (m_busy) h = 1'b0;
        if (!h) hw = 0;
        if (vic < 0) vic = lru;
        push({tg, ".hit"}, SEL_HIT, int'(h));
        push({tg, ".hitWay"}, SEL_HITWAY, hw);
        push({tg, ".victim"}, SEL_VICTIM, vic);
        push({tg, ".tagOut"}, SEL_TAG, int'(m_tag[i][wy]));
        push({tg, ".stateOut"}, SEL_STATE, int'(m_state[i][wy]));
        push({tg, ".busy"}, SEL_BUSY, int'(m_busy));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        bus.writeTag   = 1'b0;
        bus.writeState = 1'b0;
        bus.touch      = 1'b0;
        bus.flushStart = 1'b0;
    endtask

    task automatic set_in(input int i, input int w, input int t);
        bus.index = IW'(i);
        bus.wayIn = 2'(w);
        bus.tagIn = TW'(t);
    endtask

    task automatic wr(input int i, input int w, input int t, input int st);
        set_in(i, w, t);
        bus.writeTag   = 1'b1;
        bus.writeState = 1'b1;
        bus.stateIn    = SW'(st);
        tick();
    endtask

    task automatic tch(input int i, input int w);
        set_in(i, w, 0);
        bus.touch = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bus.index = '0; bus.tagIn = '0; bus.wayIn = '0; bus.stateIn = '0;
        bus.writeTag = 1'b0; bus.writeState = 1'b0; bus.touch = 1'b0; bus.flushStart = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        push("rst.busy", SEL_BUSY, 0);
        push("rst.hit", SEL_HIT, 0);
        drain();
        @(negedge clock);
        reset = 1'b1;
        #1;

        // Give every line a known tag while all states are still invalid.
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < WC; w++) begin
                set_in(s, w, 4'hE);
                bus.writeTag = 1'b1;
                tick();
            end

        set_in(1, 0, 0); #1;
        push("r31.victim", SEL_VICTIM, 0);
        push("r31.hit0", SEL_HIT, 0);
        predict("r31a"); drain();
        wr(1, 0, 'hA, 1);
        set_in(1, 0, 'hA); #1;
        push("r31.hit1", SEL_HIT, 1);
        push("r31.hitWay", SEL_HITWAY, 0);
        predict("r31b"); drain();

        for (int w = 0; w < WC; w++) wr(2, w, w + 1, 2);
        for (int w = 0; w < WC; w++) tch(2, w);
        set_in(2, 0, 3); #1;
        push("r32.victim0", SEL_VICTIM, 0);
        push("r32.hitWay2", SEL_HITWAY, 2);
        predict("r32a"); drain();
        tch(2, 0);
        set_in(2, 0, 0); #1;
        push("r32.victim1", SEL_VICTIM, 1);
        predict("r32b"); drain();

        set_in(2, 2, 0);
        bus.writeState = 1'b1; bus.stateIn = 2'd0;
        tick(); #1;
        push("r33.victim2", SEL_VICTIM, 2);
        predict("r33"); drain();

        set_in(3, 1, 5);
        bus.writeTag = 1'b1; bus.writeState = 1'b1; bus.stateIn = 2'd3; bus.touch = 1'b1;
        tick(); #1;
        push("r35.tagOut", SEL_TAG, 5);
        push("r35.stateOut", SEL_STATE, 3);
        predict("r35a"); drain();
        wr(3, 0, 6, 1); wr(3, 2, 7, 1); wr(3, 3, 8, 1);
        set_in(3, 0, 0); #1;
        push("r35.lruVictim", SEL_VICTIM, 3);
        predict("r35b"); drain();
        tch(3, 3);
        set_in(3, 0, 0); #1;
        push("r35.lruAfterTouch", SEL_VICTIM, 2);
        predict("r35c"); drain();

        // Flush launched together with a write that must still land.
        wr(0, 3, 7, 1); wr(1, 1, 9, 2);
        set_in(0, 1, 'hC);
        bus.writeTag = 1'b1; bus.writeState = 1'b1; bus.stateIn = 2'd1; bus.flushStart = 1'b1;
        tick();
        for (int cyc = 0; cyc < NS; cyc++) begin
            set_in(2, 0, 1);
            if (cyc == 1) begin
                set_in(0, 3, 'hF);
                bus.writeTag = 1'b1; bus.writeState = 1'b1; bus.stateIn = 2'd3;
                bus.touch = 1'b1; bus.flushStart = 1'b1;
            end
            #1;
            push($sformatf("r34.busy%0d", cyc), SEL_BUSY, 1);
            push($sformatf("r34.hit%0d", cyc), SEL_HIT, 0);
            predict($sformatf("r34.c%0d", cyc)); drain();
            tick();
        end
        #1;
        push("r34.busyEnd", SEL_BUSY, 0);
        drain();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < WC; w++) begin
                set_in(s, w, 0); #1;
                push($sformatf("r34.state%0d%0d", s, w), SEL_STATE, 0);
                if (w == 0) push($sformatf("r34.victim%0d", s), SEL_VICTIM, 0);
                predict($sformatf("r34.s%0dw%0d", s, w)); drain();
            end
        set_in(0, 1, 0); #1;
        push("r27.tagKept", SEL_TAG, 'hC);
        drain();
        set_in(0, 3, 0); #1;
        push("r34.noMidWrite", SEL_TAG, 7);
        drain();

        // Reset in the middle of a sweep.
        wr(1, 1, 9, 2); wr(2, 1, 2, 2); tch(2, 3);
        set_in(0, 0, 0); bus.flushStart = 1'b1;
        tick(); tick();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        push("r36.busyLow", SEL_BUSY, 0);
        predict("r36a"); drain();
        @(negedge clock);
        reset = 1'b1;
        #1;
        push("r36.busyAfter", SEL_BUSY, 0);
        drain();
        for (int s = 0; s < NS; s++) begin
            set_in(s, 1, 0); #1;
            push($sformatf("r36.victim%0d", s), SEL_VICTIM, 0);
            push($sformatf("r36.state%0d", s), SEL_STATE, 0);
            predict($sformatf("r36.s%0d", s)); drain();
        end
        for (int w = 0; w < WC; w++) wr(2, w, w + 8, 1);
        set_in(2, 0, 0); #1;
        push("r36.agesReset", SEL_VICTIM, 3);
        predict("r36b"); drain();

        for (int n = 0; n < 80; n++) begin
            set_in($urandom_range(NS - 1), $urandom_range(WC - 1), $urandom_range(15));
            bus.writeTag   = 1'($urandom_range(1));
            bus.writeState = 1'($urandom_range(1));
            bus.stateIn    = SW'($urandom_range(3));
            bus.touch      = 1'($urandom_range(1));
            bus.flushStart = ($urandom_range(19) == 0);
            #1;
            predict($sformatf("rnd%0d", n)); drain();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
